dk16_rtext_packer: RTL
======================

# dk16_rtext_packer

Downstream collector for the dk16 controller's 3-bit `rtext` response stream. It accumulates qualified response symbols into fixed-width words and buffers completed words in a small FIFO. Words drain over a valid/ready interface to the capture/readout logic. Partial words can be forced out with `flush`, and any word lost to a full FIFO is flagged.

## Interface
Parameters:
- `SYMS_PER_WORD`, default 8: symbols per word; word width W = 3*SYMS_PER_WORD (24 by default). Legal range 2..16.
- `FIFO_DEPTH`, default 4: number of word entries; power of two, at least 2.

Ports (LW = clog2(SYMS_PER_WORD+1), FW = clog2(FIFO_DEPTH+1)):
- `CLK`  in  1  single clock; all state updates on the rising edge.
- `RST`  in  1  synchronous, active-low reset.
- `rtext_in`  in  3  response symbol from the dk16 stage.
- `rtext_vld`  in  1  `rtext_in` is qualified this cycle and is consumed this cycle.
- `flush`  in  1  push the partial word now.
- `word_out`  out  W  head-of-FIFO word; symbol k occupies bits [3k+2:3k].
- `word_len`  out  LW  number of valid symbols in `word_out` (1..SYMS_PER_WORD).
- `word_vld`  out  1  FIFO not empty.
- `word_rdy`  in  1  consumer accepts the head word.
- `fifo_level`  out  FW  occupied entries.
- `overflow`  out  1  sticky flag: a word was dropped.
- `clr_ovf`  in  1  clears `overflow`.

## Operation
- Accumulator: W-bit shift register `acc` and symbol index `idx` (0..SYMS_PER_WORD-1).
- When `rtext_vld`=1: `rtext_in` is written at slot `idx`, then `idx` increments.
- Full word: the accepted symbol lands in slot SYMS_PER_WORD-1. The word is pushed with len=SYMS_PER_WORD, `acc` is cleared and `idx` returns to 0.
- Flush: when `flush`=1 and the post-accept count is greater than 0 and less than SYMS_PER_WORD:
  - Push `acc` with unused slots zero and len = count.
  - Clear `acc` and set `idx` to 0.
- A symbol arriving in the same cycle as `flush` is included in the flushed word.
- If that symbol completes the word, exactly one push occurs, with full length.
- `flush` with count 0 is a no-op.
- Pop: occurs when `word_vld`=1 and `word_rdy`=1.
- Push while full:
  - With a simultaneous pop: the push succeeds and the level is unchanged.
  - Without a pop: the word is dropped, `overflow` is set to 1, and the accumulator is still cleared.
- `overflow` clears only on reset or `clr_ovf`=1. If a set and `clr_ovf` occur in the same cycle, set wins.
- When the FIFO is empty, `word_out` and `word_len` are driven to 0.
- Words leave the FIFO in push order. Each pushed word carries its length alongside it.

## Timing
- Reset (`RST`=0 at an edge): clears `acc`, `idx` and the FIFO. After reset: `word_out`=0, `word_len`=0, `word_vld`=0, `fifo_level`=0, `overflow`=0.
- Reset mid-word discards the partial word. Reset has priority over every other input.
- Latency: when the completing symbol or `flush` is sampled at edge N and the FIFO was empty, `word_vld`=1 with the new word during cycle N+1.
- Handshake:
  - A pop takes effect at the edge where `word_vld`&&`word_rdy`; the next head entry (or 0s if empty) appears after that edge.
  - `word_out` and `word_len` are stable while `word_vld`=1 and `word_rdy`=0.
  - `word_rdy` may be held high continuously, giving one word per cycle maximum.
- `fifo_level` and `overflow` are registered and reflect state after the most recent edge.
- Throughput: one symbol accepted every cycle, with no back-pressure on `rtext_in`. Loss is possible only through overflow.
- Read/write pointers wrap modulo FIFO_DEPTH. Full is indicated by `fifo_level`=FIFO_DEPTH.

## Test plan
All scenarios use default parameters.
- Full word: symbols 1,2,3,4,5,6,7,0 on 8 consecutive cycles with `word_rdy`=1. Required: one cycle after the 8th symbol, `word_vld`=1, `word_out`=0x1F58D1, `word_len`=8; the word pops and `fifo_level` returns to 0.
- Partial flush: symbols 5,5,5, then `flush` alone. Required: `word_out`=0x00016D, `word_len`=3. A second `flush` with no symbols produces no push.
- Flush coincident with symbol: 7 symbols of value 1, then 8th symbol 1 with `flush`=1. Required: exactly one word 0x249249, `word_len`=8, `fifo_level`=1.
- Overflow: `word_rdy`=0, push 5 full words. Required: `fifo_level`=4 and `overflow`=1 after the 5th push, with the 5th word dropped. With `word_rdy`=1, words 1-4 drain in order. Pulse `clr_ovf`: `overflow`=0.
- Full with simultaneous pop: FIFO holds 4 words and `word_rdy`=1 on the cycle a 5th word completes. Required: `fifo_level` stays 4, `overflow` stays 0, and the 5th word emerges last.
- Reset mid-word: 4 symbols, then `RST`=0 for 1 cycle, then 8 symbols of value 2. Required: all outputs 0 during reset. Exactly one word 0x492492 results, containing no pre-reset data.

Source files
------------

// File: rtl/dk16_rtext_packer.sv
// Packs the dk16 3-bit rtext response stream into fixed-width words and buffers them
// in a small FIFO that drains over a valid/ready interface. Dropped words raise a sticky flag.
module dk16_rtext_packer #(
   parameter int SYMS_PER_WORD = 8,
   parameter int FIFO_DEPTH    = 4,
   localparam int W  = 3 * SYMS_PER_WORD,
   localparam int LW = $clog2(SYMS_PER_WORD + 1),
   localparam int FW = $clog2(FIFO_DEPTH + 1)
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic [2:0]    rtext_in,
   input  logic          rtext_vld,
   input  logic          flush,
   output logic [W-1:0]  word_out,
   output logic [LW-1:0] word_len,
   output logic          word_vld,
   input  logic          word_rdy,
   output logic [FW-1:0] fifo_level,
   output logic          overflow,
   input  logic          clr_ovf
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [LW-1:0] SYMS_L   = LW'(SYMS_PER_WORD);
   localparam logic [LW-1:0] LAST_IDX = LW'(SYMS_PER_WORD - 1);
   localparam logic [FW-1:0] DEPTH_L  = FW'(FIFO_DEPTH);

   logic [W-1:0]  acc_p0;
   logic [LW-1:0] idx_p0;
   logic [W-1:0]  acc_nx;
   logic [LW-1:0] cnt_nx;

   logic [W-1:0]  mem_data [FIFO_DEPTH];
   logic [LW-1:0] mem_len  [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [FW-1:0] level;
   logic          ovf_q;

   logic          full_push;
   logic          flush_push;
   logic          push;
   logic          pop;
   logic          fifo_full;
   logic          wr_en;
   logic          drop;

   // Accumulator next state: the incoming symbol lands at slot idx before any push decision,
   // so a symbol coinciding with flush is part of the flushed word.
   always_comb begin
      acc_nx = acc_p0;
      for (int k = 0; k < SYMS_PER_WORD; k++) begin
         if (rtext_vld && (idx_p0 == LW'(k))) begin
            acc_nx[3*k +: 3] = rtext_in;
         end
      end
      cnt_nx     = idx_p0 + LW'(rtext_vld);
      full_push  = rtext_vld && (idx_p0 == LAST_IDX);
      flush_push = flush && (cnt_nx != '0) && (cnt_nx < SYMS_L);
      push       = full_push || flush_push;
      fifo_full  = (level == DEPTH_L);
      pop        = (level != '0) && word_rdy;
      wr_en      = push && (!fifo_full || pop);
      drop       = push && fifo_full && !pop;
   end

   // Stage p0: accumulator, FIFO pointers, level and sticky overflow
   always_ff @(posedge CLK) begin
      if (!RST) begin
         acc_p0 <= '0;
         idx_p0 <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         if (push) begin
            acc_p0 <= '0;
            idx_p0 <= '0;
         end else if (rtext_vld) begin
            acc_p0 <= acc_nx;
            idx_p0 <= cnt_nx;
         end

         if (wr_en) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end

         case ({wr_en, pop})
            2'b10:   level <= level + FW'(1);
            2'b01:   level <= level - FW'(1);
            default: level <= level;
         endcase

         if (drop) begin
            ovf_q <= 1'b1;
         end else if (clr_ovf) begin
            ovf_q <= 1'b0;
         end
      end
   end

   // Storage carries no reset; emptiness is tracked by level and masks the outputs.
   always_ff @(posedge CLK) begin
      if (wr_en) begin
         mem_data[wr_ptr] <= acc_nx;
         mem_len[wr_ptr]  <= cnt_nx;
      end
   end

   always_comb begin
      word_vld   = (level != '0);
      word_out   = word_vld ? mem_data[rd_ptr] : '0;
      word_len   = word_vld ? mem_len[rd_ptr]  : '0;
      fifo_level = level;
      overflow   = ovf_q;
   end

endmodule
